sm_hex_scan: RTL and testbench
==============================

SM_HEX_SCAN -- requirements
Module: sm_hex_scan

Interface
REQ-001 Parameter SHIFT, default 10, prescaler width; one digit step every 2^SHIFT clkIn cycles.
REQ-002 Parameter BLANK, default 4, anode dead-time in cycles after each digit step; legal range 0 to 2^SHIFT-1.
REQ-003 clkIn  input  1  single clock for all state; one clock, reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clkIn.
REQ-005 data  input  32  value to display, eight hex nibbles, nibble 0 = rightmost digit.
REQ-006 load  input  1  one-cycle strobe capturing data into the shadow register.
REQ-007 digitMask  input  8  per-digit enable, bit i enables digit i.
REQ-008 lzBlank  input  1  leading-zero suppression enable.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered, constant 1.
REQ-011 anode  output  8  digit select, active-low, at most one bit low, registered.
REQ-012 frameDone  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Function
REQ-013 Prescaler: SHIFT-bit free-running counter; tick asserted in the cycle the counter equals 2^SHIFT-1, then wraps to 0.
REQ-014 Digit index: 3-bit counter; on tick increments, 7 wraps to 0; no other change.
REQ-015 Wrap tick = tick while index is 7; frameDone = 1 in the cycle after the wrap tick, otherwise 0.
REQ-016 load=1: shadow <= data, pending <= 1, in the same cycle.
REQ-017 Wrap tick with pending=1 and load=0: display <= shadow, pending <= 0.
REQ-018 Wrap tick with load=1: display <= data, shadow <= data, pending <= 0 (newest data wins, no lost frame).
REQ-019 display changes only on wrap ticks; no mid-frame tearing.
REQ-020 Nibble n = display[4*index+3 : 4*index]; seg is the standard hex decode 0-F (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110), one cycle after index update.
REQ-021 Digit i is visible when digitMask[i]=1 and not leading-zero blanked.
REQ-022 Leading-zero blanked: lzBlank=1, i>0, and display nibbles i..7 all zero; digit 0 is never leading-zero blanked.
REQ-023 anode[index]=0 only when the current digit is visible and the prescaler count is >= BLANK; all other anode bits 1.
REQ-024 Invisible digit: anode all 1, seg 7'h7F.
REQ-025 BLANK=0: no dead time; anode active for the full digit period.
REQ-026 digitMask and lzBlank are sampled live each cycle, not latched at frame boundary.

Reset
REQ-027 rst=1 forces: prescaler 0, index 0, shadow 0, display 0, pending 0, anode 8'hFF, seg 7'h7F, dp 1, frameDone 0.
REQ-028 rst overrides load and tick in the same cycle; reset mid-frame discards pending data.
REQ-029 First cycle after rst released: prescaler counts from 0, digit 0 scanned first.

Verification (SHIFT=2, BLANK=1)
REQ-030 Reset then run 32 cycles, digitMask=8'hFF, lzBlank=0 -> anode walks FE,FD,...,7F, each low for 3 of 4 cycles, seg=7'b1000000, frameDone pulse every 32 cycles.
REQ-031 load data=32'h89ABCDEF mid-frame -> display unchanged until wrap tick; next frame digit0 seg=F, digit7 seg=8.
REQ-032 load 32'h11111111 then load 32'h22222222 in the wrap-tick cycle -> next frame all digits show 2, pending=0.
REQ-033 data=32'h00000A00, lzBlank=1 -> digits 3..7 anode stay high, digits 2,1,0 show A,0,0.
REQ-034 data=32'h0, lzBlank=1 -> only digit 0 lights, shows 0; digitMask=8'hFE -> no anode ever low.
REQ-035 rst asserted while pending=1 at index 5 -> next cycle anode 8'hFF, seg 7'h7F; after release display=0, scan restarts at digit 0.

Source files
------------

// File: rtl/sm_hex_scan.sv
// Eight-digit multiplexed hex display scanner with a double-buffered value,
// anode dead-time and leading-zero suppression.

module sm_hex_digit (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       lz_blk,
  output logic       vis,
  output logic [6:0] dec
);
  assign vis = en && !lz_blk;

  // {g,f,e,d,c,b,a}, active-low
  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = 7'h7F;
    endcase
  end
endmodule

module sm_hex_scan #(
  parameter int SHIFT = 10,
  parameter int BLANK = 4
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  digitMask,
  input  logic        lzBlank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  anode,
  output logic        frameDone
);
  localparam int NUM_DIG = 8;
  localparam logic [SHIFT-1:0] ONE     = 1;
  localparam logic [SHIFT-1:0] BLANK_C = SHIFT'(BLANK);

  logic [SHIFT-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      shadow, disp;
  logic             pending;
  logic             tick, wrap, lit_ok;

  logic [NUM_DIG-1:0]      hi_zero, lz_blk, vis_v;
  logic [NUM_DIG-1:0][6:0] dec_v;
  logic                    cur_vis;
  logic [6:0]              cur_dec;

  assign tick = &cnt;
  assign wrap = tick && (idx == 3'd7);

  generate
    if (BLANK == 0) begin : g_noblank
      assign lit_ok = 1'b1;
    end else begin : g_blank
      assign lit_ok = (cnt >= BLANK_C);
    end
  endgenerate

  // hi_zero[i]: nibbles i..7 are all zero
  genvar i;
  generate
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
      assign hi_zero[i] = ~|disp[31:4*i];
      if (i == 0) begin : g_d0
        assign lz_blk[i] = 1'b0;
      end else begin : g_dn
        assign lz_blk[i] = lzBlank && hi_zero[i];
      end
      sm_hex_digit u_dig (
        .nib    (disp[4*i +: 4]),
        .en     (digitMask[i]),
        .lz_blk (lz_blk[i]),
        .vis    (vis_v[i]),
        .dec    (dec_v[i])
      );
    end
  endgenerate

  assign cur_vis = vis_v[idx];
  assign cur_dec = dec_v[idx];

  always_ff @(posedge clkIn) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= 3'd0;
      shadow    <= '0;
      disp      <= '0;
      pending   <= 1'b0;
      anode     <= 8'hFF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      frameDone <= 1'b0;
    end else begin
      cnt       <= cnt + ONE;
      if (tick) idx <= idx + 3'd1;
      frameDone <= wrap;
      dp        <= 1'b1;
      // display only swaps at frame boundaries; a load on the wrap tick goes straight in
      if (wrap) begin
        if (load) begin
          disp    <= data;
          shadow  <= data;
        end else if (pending) begin
          disp    <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= data;
        pending <= 1'b1;
      end
      seg   <= cur_vis ? cur_dec : 7'h7F;
      anode <= (cur_vis && lit_ok) ? ~(8'h01 << idx) : 8'hFF;
    end
  end
endmodule

// File: tb/tb_sm_hex_scan.sv
// Scoreboard bench for sm_hex_scan at SHIFT=2, BLANK=1.

module tb_sm_hex_scan;
  localparam int SHIFT = 2;
  localparam int BLANK = 1;

  logic        clkIn = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        load = 1'b0;
  logic [7:0]  digitMask = 8'hFF;
  logic        lzBlank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  anode;
  logic        frameDone;

  sm_hex_scan #(.SHIFT(SHIFT), .BLANK(BLANK)) dut (
    .clkIn(clkIn), .rst(rst), .data(data), .load(load),
    .digitMask(digitMask), .lzBlank(lzBlank),
    .seg(seg), .dp(dp), .anode(anode), .frameDone(frameDone)
  );

  always #5 clkIn = ~clkIn;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int n_tests = 0, n_fail = 0;
  int lit_cnt = 0, fd_cnt = 0;

  // bench model state
  int          m_cyc = 0;
  logic [31:0] m_disp = '0, m_sh = '0;
  logic        m_pend = 1'b0;

  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive one cycle of inputs, push the outputs the next edge must produce
  task automatic step(input logic ld, input logic [31:0] d);
    exp_t e;
    int   cnt, idx, hi;
    logic vis;
    load = ld;
    data = d;
    if (rst) begin
      e = '{an: 8'hFF, sg: 7'h7F, dp: 1'b1, fd: 1'b0};
      m_cyc = 0; m_disp = '0; m_sh = '0; m_pend = 1'b0;
    end else begin
      cnt = m_cyc % 4;
      idx = (m_cyc / 4) % 8;
      hi = -1;
      for (int k = 0; k < 8; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
      vis  = digitMask[idx] && !(lzBlank && idx > 0 && idx > hi);
      e.sg = vis ? hex7[m_disp[4*idx +: 4]] : 7'h7F;
      e.an = (vis && cnt >= BLANK) ? ~(8'h01 << idx) : 8'hFF;
      e.dp = 1'b1;
      e.fd = (m_cyc % 32 == 31);
      if (m_cyc % 32 == 31) begin
        if (ld) begin m_disp = d; m_sh = d; end
        else if (m_pend) m_disp = m_sh;
        m_pend = 1'b0;
      end else if (ld) begin
        m_sh = d; m_pend = 1'b1;
      end
      m_cyc++;
    end
    q.push_back(e);
    @(negedge clkIn);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0);
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < 64 && (m_cyc % 32) != phase; k++) step(1'b0, 32'h0);
  endtask

  always @(posedge clkIn) begin
    #1;
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("anode", anode, e_mon.an);
      chk("seg", seg, e_mon.sg);
      chk("dp", dp, e_mon.dp);
      chk("frameDone", frameDone, e_mon.fd);
      chk("one_hot_low", ($countones(~anode) <= 1), 1);
      if (anode != 8'hFF) lit_cnt++;
      if (frameDone) fd_cnt++;
    end
  end

  initial begin
    @(negedge clkIn);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // free scan of zeros: two frames
    lit_cnt = 0; fd_cnt = 0;
    idle(64);
    chk("scan_lit", lit_cnt, 48);
    chk("scan_fd", fd_cnt, 2);

    // mid-frame load held off until the wrap
    run_to(10);
    step(1'b1, 32'h89ABCDEF);
    idle(60);

    // newest data wins on the wrap tick
    run_to(5);
    step(1'b1, 32'h11111111);
    run_to(31);
    step(1'b1, 32'h22222222);
    idle(40);

    // leading-zero suppression
    lzBlank = 1'b1;
    step(1'b1, 32'h00000A00);
    run_to(0);
    lit_cnt = 0;
    idle(32);
    chk("lz_a00_lit", lit_cnt, 9);

    step(1'b1, 32'h0);
    run_to(0);
    lit_cnt = 0;
    idle(32);
    chk("lz_zero_lit", lit_cnt, 3);
    digitMask = 8'hFE;
    lit_cnt = 0;
    idle(32);
    chk("mask_fe_lit", lit_cnt, 0);

    // reset while a load is pending at digit 5
    digitMask = 8'hFF;
    lzBlank = 1'b0;
    step(1'b1, 32'h12345678);
    run_to(0);
    step(1'b1, 32'hDEADBEEF);
    run_to(20);
    rst = 1'b1;
    step(1'b1, 32'hCAFEF00D);
    rst = 1'b0;
    lit_cnt = 0; fd_cnt = 0;
    idle(32);
    chk("post_rst_lit", lit_cnt, 24);
    chk("post_rst_fd", fd_cnt, 1);
    idle(32);

    // random traffic with live mask/lz changes
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 31) == 0) digitMask = 8'($urandom);
      if ($urandom_range(0, 31) == 0) lzBlank = 1'($urandom);
      if ($urandom_range(0, 15) == 0) data = {$urandom_range(0, 1) ? 16'h0 : 16'($urandom), 16'($urandom)};
      step($urandom_range(0, 11) == 0, data);
    end

    @(posedge clkIn); #2;
    chk("q_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
